ps2_host_tx: RTL and testbench

PS/2 host-to-device transmitter. It sends command bytes to the keyboard, such as 0xED to set the LEDs or 0xFF to reset it. It is the opposite direction of the existing PS/2 keyboard receiver inside the ULA and shares the same open-drain PS2_CLK/PS2_DAT lines. It sits beside the receiver in the ULA clock domain, and the top level converts its drive-low outputs to open-drain pads.

---
 rtl/ps2_host_tx.sv | 198 +++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
`timescale 1ns/1ps
// PS/2 host-to-device command sender: clock inhibit, request-to-send, 11-edge framed byte, ACK check.
// Transfer starts the cycle after tx_valid in IDLE. No queue: tx_ready stays low until the tx_done pulse ends.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES        = 1200,
  parameter int START_TIMEOUT_CYCLES  = 150000,
  parameter int PACKET_TIMEOUT_CYCLES = 20000,
  parameter int FILTER_LEN            = 8
) (
  input  logic       CLOCK_10,
  input  logic       nreset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic [1:0] tx_status,
  output logic       rx_inhibit,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_drive_low,
  output logic       ps2_dat_drive_low
);

  localparam int MAX_A = (START_TIMEOUT_CYCLES > PACKET_TIMEOUT_CYCLES) ?
                         START_TIMEOUT_CYCLES : PACKET_TIMEOUT_CYCLES;
  localparam int MAX_T = (MAX_A > INHIBIT_CYCLES) ? MAX_A : INHIBIT_CYCLES;
  localparam int TW    = $clog2(MAX_T) + 1;
  localparam int FW    = $clog2(FILTER_LEN) + 1;

  localparam logic [TW-1:0] T_INH_LAST = TW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] T_START    = TW'(START_TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] T_PACKET   = TW'(PACKET_TIMEOUT_CYCLES);
  localparam logic [FW-1:0] F_LAST     = FW'(FILTER_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_DATA, S_ACK, S_WAIT_IDLE, S_DONE, S_FAIL
  } state_t;

  state_t            state, state_n;
  logic [1:0]        clk_sync, dat_sync;
  logic [1:0]        raw, filt;
  logic [1:0][FW-1:0] fcnt;
  logic              clk_f, dat_f, clk_f_q, fall;
  logic [8:0]        shift, shift_n;
  logic [TW-1:0]     timer, timer_n, timer_inc;
  logic [3:0]        edge_cnt, edge_n;
  logic              dat_q, dat_n, nack, nack_n, pkt_expired;

  always_ff @(posedge CLOCK_10 or negedge nreset) begin
    if (!nreset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk_in};
      dat_sync <= {dat_sync[0], ps2_dat_in};
    end
  end

  assign raw = {clk_sync[1], dat_sync[1]};

  // A lane flips only after FILTER_LEN consecutive samples disagree with it.
  always_ff @(posedge CLOCK_10 or negedge nreset) begin
    if (!nreset) begin
      filt <= 2'b11;
      fcnt <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (raw[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == F_LAST) begin
          filt[i] <= raw[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + 1'b1;
        end
      end
    end
  end

  assign clk_f = filt[1];
  assign dat_f = filt[0];

  always_ff @(posedge CLOCK_10 or negedge nreset) begin
    if (!nreset) begin
      clk_f_q <= 1'b1;
      fall    <= 1'b0;
    end else begin
      clk_f_q <= clk_f;
      fall    <= clk_f_q & ~clk_f;
    end
  end

  always_ff @(posedge CLOCK_10 or negedge nreset) begin
    if (!nreset) begin
      state    <= S_IDLE;
      shift    <= '0;
      timer    <= '0;
      edge_cnt <= '0;
      dat_q    <= 1'b0;
      nack     <= 1'b0;
    end else begin
      state    <= state_n;
      shift    <= shift_n;
      timer    <= timer_n;
      edge_cnt <= edge_n;
      dat_q    <= dat_n;
      nack     <= nack_n;
    end
  end

  always_comb begin
    state_n     = state;
    shift_n     = shift;
    timer_n     = timer;
    edge_n      = edge_cnt;
    dat_n       = dat_q;
    nack_n      = nack;
    timer_inc   = (timer == {TW{1'b1}}) ? timer : timer + 1'b1;
    pkt_expired = (timer >= T_PACKET);

    case (state)
      S_IDLE: begin
        if (tx_valid) begin
          shift_n = {~^tx_data, tx_data};
          timer_n = '0;
          edge_n  = '0;
          nack_n  = 1'b0;
          dat_n   = 1'b0;
          state_n = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        timer_n = timer_inc;
        if (timer == T_INH_LAST) begin
          timer_n = '0;
          dat_n   = 1'b1;
          state_n = S_REQ;
        end
      end
      S_REQ: begin
        timer_n = timer_inc;
        if (fall) begin
          // First device edge clocks bit 0 and restarts the timer for the packet budget.
          edge_n  = 4'd1;
          dat_n   = ~shift[0];
          timer_n = '0;
          state_n = S_DATA;
        end else if (timer == T_START) begin
          dat_n   = 1'b0;
          state_n = S_FAIL;
        end
      end
      S_DATA: begin
        timer_n = timer_inc;
        if (pkt_expired) begin
          dat_n   = 1'b0;
          state_n = S_FAIL;
        end else if (fall) begin
          edge_n = edge_cnt + 4'd1;
          if (edge_cnt == 4'd9) begin
            dat_n   = 1'b0;
            state_n = S_ACK;
          end else begin
            dat_n = ~shift[edge_cnt];
          end
        end
      end
      S_ACK: begin
        timer_n = timer_inc;
        if (pkt_expired) begin
          state_n = S_FAIL;
        end else if (fall) begin
          edge_n  = 4'd11;
          nack_n  = dat_f;
          state_n = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        timer_n = timer_inc;
        if (pkt_expired)        state_n = S_FAIL;
        else if (clk_f && dat_f) state_n = S_DONE;
      end
      S_DONE:  state_n = S_IDLE;
      S_FAIL:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    tx_ready          = (state == S_IDLE);
    rx_inhibit        = (state != S_IDLE);
    tx_done           = (state == S_DONE) || (state == S_FAIL);
    tx_status         = (state == S_FAIL) ? 2'b10 :
                        (state == S_DONE) ? {1'b0, nack} : 2'b00;
    ps2_clk_drive_low = (state == S_INHIBIT);
    // Start bit appears during the final inhibit cycle, ahead of the clock release.
    ps2_dat_drive_low = dat_q | ((state == S_INHIBIT) && (timer == T_INH_LAST));
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
// Directed bench: PS/2 device model on an open-drain bus plus a per-cycle transfer model.
module tb_ps2_host_tx;
  localparam int INH = 1200;
  localparam int STO = 3000;
  localparam int PTO = 2000;
  localparam int FLT = 8;
  localparam int H   = 40;

  logic       CLOCK_10 = 1'b0;
  logic       nreset   = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_done, rx_inhibit, ps2_clk_drive_low, ps2_dat_drive_low;
  logic [1:0] tx_status;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  logic       bus_clk, bus_dat;

  assign bus_clk = ~(ps2_clk_drive_low | dev_clk_low);
  assign bus_dat = ~(ps2_dat_drive_low | dev_dat_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH), .START_TIMEOUT_CYCLES(STO),
    .PACKET_TIMEOUT_CYCLES(PTO), .FILTER_LEN(FLT)
  ) dut (
    .CLOCK_10(CLOCK_10), .nreset(nreset),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_done(tx_done), .tx_status(tx_status), .rx_inhibit(rx_inhibit),
    .ps2_clk_in(bus_clk), .ps2_dat_in(bus_dat),
    .ps2_clk_drive_low(ps2_clk_drive_low), .ps2_dat_drive_low(ps2_dat_drive_low)
  );

  always #50 CLOCK_10 = ~CLOCK_10;

  int         vectors = 0;
  int         miscompares = 0;
  bit         m_busy = 1'b0;
  int         m_k = 0;
  logic [1:0] m_exp_status = 2'b00;
  bit         m_chk_timing = 1'b0;
  bit         was_idle;
  int         dev_falls = 0;
  int         run_len = 0;
  int         last_low_len = 0;
  int         done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h, t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLOCK_10);
      #1;
    end
  endtask

  // Transfer model: acceptance when idle with tx_valid; inhibit window, start bit and release timing by cycle count.
  always @(negedge CLOCK_10) begin
    if (!nreset) begin
      m_busy  = 1'b0;
      run_len = 0;
    end else begin
      was_idle = !m_busy;
      if (ps2_clk_drive_low) run_len++;
      else if (run_len != 0) begin
        last_low_len = run_len;
        run_len = 0;
      end
      if (m_busy) begin
        m_k++;
        check("busy_ready", tx_ready, 0);
        check("busy_rx_inhibit", rx_inhibit, 1);
        if (m_k <= INH) begin
          check("inhibit_clk_low", ps2_clk_drive_low, 1);
          check("inhibit_dat", ps2_dat_drive_low, (m_k == INH));
        end else begin
          check("released_clk", ps2_clk_drive_low, 0);
          if (dev_falls == 0 && !tx_done) check("req_start_bit", ps2_dat_drive_low, 1);
        end
        if (tx_done) begin
          done_cnt++;
          check("status", tx_status, m_exp_status);
          if (m_chk_timing)
            check("timeout_latency", ((m_k - 1 >= INH + STO - 2) && (m_k - 1 <= INH + STO + 2)), 1);
          m_busy = 1'b0;
        end
      end else begin
        check("idle_ready", tx_ready, 1);
        check("idle_rx_inhibit", rx_inhibit, 0);
        check("idle_no_done", tx_done, 0);
        check("idle_clk_rel", ps2_clk_drive_low, 0);
        check("idle_dat_rel", ps2_dat_drive_low, 0);
      end
      if (was_idle && tx_valid) begin
        m_busy = 1'b1;
        m_k    = 0;
      end
    end
  end

  task automatic send(input logic [7:0] d);
    @(posedge CLOCK_10); #1;
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge CLOCK_10); #1;
    tx_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    int start;
    n = 0;
    start = done_cnt;
    while (done_cnt == start && n < budget) begin
      @(negedge CLOCK_10); #1;
      n++;
    end
    check("done_seen", (done_cnt != start), 1);
  endtask

  // Device: waits for request-to-send, clocks 11 edges, samples DAT at each rising edge, optional ACK.
  task automatic dev_xfer(input int stop_after, input bit ack, input bit glitch,
                          output logic [9:0] got, output bit ok);
    int n;
    got = '0;
    ok  = 1'b0;
    n   = 0;
    while (bus_clk !== 1'b0 && n < 20) begin @(negedge CLOCK_10); n++; end
    if (bus_clk !== 1'b0) return;
    n = 0;
    while (!(bus_clk === 1'b1 && bus_dat === 1'b0) && n < INH + 100) begin
      @(negedge CLOCK_10); n++;
    end
    if (!(bus_clk === 1'b1 && bus_dat === 1'b0)) return;
    ok = 1'b1;
    tick(30);
    for (int i = 1; i <= 11; i++) begin
      dev_clk_low = 1'b1;
      dev_falls   = i;
      if (i == stop_after) return;
      tick(H);
      if (i <= 10) got[i-1] = bus_dat;
      dev_clk_low = 1'b0;
      if (i == 11) begin
        dev_dat_low = 1'b0;
      end else if (glitch && i == 4) begin
        tick(10);
        dev_clk_low = 1'b1;
        tick(5);
        dev_clk_low = 1'b0;
        tick(H - 15);
      end else if (i == 10) begin
        tick(H / 2);
        dev_dat_low = ack;
        tick(H - H / 2);
      end else begin
        tick(H);
      end
    end
  endtask

  task automatic run_xfer(input logic [7:0] d, input bit ack, input bit glitch,
                          input bit busy_poke, input bit hold_next, output logic [9:0] got);
    bit ok;
    dev_falls    = 0;
    m_exp_status = ack ? 2'b00 : 2'b01;
    m_chk_timing = 1'b0;
    send(d);
    if (busy_poke) begin
      fork
        dev_xfer(0, ack, glitch, got, ok);
        begin
          tick(1300);
          tx_data  = 8'hAA;
          tx_valid = 1'b1;
          tick(2);
          tx_valid = 1'b0;
        end
      join
    end else begin
      dev_xfer(0, ack, glitch, got, ok);
    end
    check("device_handshake", ok, 1);
    check("frame_bits", got, {1'b1, ~^d, d});
    if (hold_next) begin
      tx_data  = 8'h33;
      tx_valid = 1'b1;
    end
    wait_done(200);
    check("inhibit_length", last_low_len, INH);
  endtask

  initial begin
    logic [9:0] got;
    int         d0;
    bit         ok;

    tick(3);
    check("rst_ready", tx_ready, 1);
    check("rst_done", tx_done, 0);
    check("rst_status", tx_status, 2'b00);
    check("rst_rx_inhibit", rx_inhibit, 0);
    check("rst_clk_drive", ps2_clk_drive_low, 0);
    check("rst_dat_drive", ps2_dat_drive_low, 0);
    nreset = 1'b1;
    tick(20);

    run_xfer(8'hED, 1'b1, 1'b0, 1'b0, 1'b0, got);
    check("frame_ED_literal", got, 10'h3ED);
    tick(5);
    run_xfer(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, got);
    check("frame_FF_literal", got, 10'h3FF);
    tick(5);

    // tx_valid held through tx_done: accepted only from the following idle cycle; no device answers it.
    run_xfer(8'h01, 1'b0, 1'b0, 1'b0, 1'b1, got);
    check("frame_01_literal", got, 10'h201);
    m_exp_status = 2'b10;
    m_chk_timing = 1'b1;
    dev_falls    = 0;
    tick(2);
    tx_valid = 1'b0;
    wait_done(INH + STO + 100);
    tick(3);
    check("timeout_clk_released", ps2_clk_drive_low, 0);
    check("timeout_dat_released", ps2_dat_drive_low, 0);
    m_chk_timing = 1'b0;

    d0 = done_cnt;
    dev_falls    = 0;
    m_exp_status = 2'b00;
    send(8'h2C);
    dev_xfer(5, 1'b1, 1'b0, got, ok);
    tick(20);
    check("pre_reset_dat_low", ps2_dat_drive_low, 1);
    #2 nreset = 1'b0;
    #1;
    check("async_rst_clk_rel", ps2_clk_drive_low, 0);
    check("async_rst_dat_rel", ps2_dat_drive_low, 0);
    check("async_rst_no_done", tx_done, 0);
    dev_clk_low = 1'b0;
    tick(5);
    nreset = 1'b1;
    tick(20);
    check("no_done_after_reset", done_cnt, d0);

    run_xfer(8'hF4, 1'b1, 1'b0, 1'b0, 1'b0, got);
    tick(5);
    run_xfer(8'h5A, 1'b1, 1'b1, 1'b0, 1'b0, got);
    tick(5);
    run_xfer(8'h0F, 1'b1, 1'b0, 1'b1, 1'b0, got);
    tick(5);
    check("total_done_pulses", done_cnt, 7);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #(100 * 60000);
    miscompares++;
    $display("FAIL watchdog: bench still running at %0t, required end within 60000 cycles", $time);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog expired");
  end

endmodule
